// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and types for the instruction fetch path.
//   XLEN / INSTR_W   : datapath and instruction widths
//   RESET_PC_DEFAULT : default fetch PC after reset
//   PC_STEP          : sequential fetch increment
//   fq_entry_t       : fetch queue entry {instr, npc}
//   fq_state_e       : fetch queue state (RUN / DRAIN)
//   align_pc()       : force a fetch address to word alignment
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    npc;
  } fq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fq_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle around the fetch queue.
//   req_*      : fetch request channel toward instruction memory
//   resp_*     : in-order instruction return from memory
//   redirect*  : flush and refetch from a new PC
//   out_*      : valid/ready channel toward the IF/ID register
// Modports: master = fetch queue side, slave = memory / pipeline side.
interface fetch_queue_if;
  import cpu_pkg::*;

  logic               req_valid;
  logic [XLEN-1:0]    req_addr;
  logic               req_ready;
  logic               resp_valid;
  logic [INSTR_W-1:0] resp_instr;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_npc;

  modport master (
    output req_valid, req_addr,
    input  req_ready,
    input  resp_valid, resp_instr,
    input  redirect, redirect_pc,
    output out_valid, out_instr, out_npc,
    input  out_ready
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready,
    output resp_valid, resp_instr,
    output redirect, redirect_pc,
    input  out_valid, out_instr, out_npc,
    output out_ready
  );

endinterface

// File: rtl/fq_ring.sv
// fq_ring: power-of-two ring buffer with push, pop, clear and head peek.
//   clk, reset : clock, synchronous active-high reset
//   clear      : empty the ring (wins over push/pop)
//   push/push_data : write at tail
//   pop        : advance head
//   head_data  : entry at head (meaningful only when count != 0)
//   count      : number of stored entries, 0..DEPTH
module fq_ring #(
  parameter int  DEPTH = 4,
  parameter int  W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           head_q, head_d;
  logic [AW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and IF/ID.
// Owns the fetch PC, issues in-order requests under a credit limit of DEPTH
// (buffered + in flight), buffers returned words with their NPC, and flushes
// on redirect while discarding responses still in flight.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_queue_if.master (req_*, resp_*, redirect*, out_*)
// Build option: FETCHQ_BYPASS_EN -- a response arriving at an empty queue
// drives out_* in the same cycle (0-cycle latency). Undefined: every response
// goes through storage and out_* is purely registered (1-cycle latency).
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.master bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int ENT_W = $bits(fq_entry_t);

  fq_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  fq_entry_t       last_q, last_d;

  logic [CW-1:0]   count, tag_count;
  logic [XLEN-1:0] tag_head;
  fq_entry_t       ent_head, resp_ent, out_ent;
  logic [CW:0]     occupancy;
  logic            out_vld, byp;
  logic            req_fire, resp_take, resp_drop, push, pop;

  // ---------------------------------------------------------------- request
  assign occupancy     = {1'b0, count} + {1'b0, inflight_q};
  assign bus.req_valid = !reset && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
  assign bus.req_addr  = pc_q;
  assign req_fire      = bus.req_valid && bus.req_ready;

  // --------------------------------------------------------------- response
  // Responses return in order, so anything arriving while drop_cnt is
  // non-zero belongs to the pre-redirect stream.
  assign resp_take = bus.resp_valid && (state_q == RUN);
  assign resp_drop = bus.resp_valid && (state_q == DRAIN);
  assign resp_ent  = '{instr: bus.resp_instr, npc: tag_head + PC_STEP};

  // ----------------------------------------------------------------- output
  always_comb begin
    out_vld = (count != '0);
    out_ent = (count != '0) ? ent_head : last_q;
    byp     = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    if (resp_take && count == '0) begin
      byp     = 1'b1;
      out_vld = 1'b1;
      out_ent = resp_ent;
    end
`endif
  end

  assign bus.out_valid = out_vld;
  assign bus.out_instr = out_ent.instr;
  assign bus.out_npc   = out_ent.npc;

  // Redirect voids any same-cycle handshake; a bypassed word that is
  // consumed immediately never touches storage.
  assign push = resp_take && !bus.redirect && !(byp && bus.out_ready);
  assign pop  = (count != '0) && bus.out_ready && !bus.redirect;

  fq_ring #(.DEPTH(DEPTH), .W(ENT_W)) u_entries (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect),
    .push      (push),
    .push_data (resp_ent),
    .pop       (pop),
    .head_data (ent_head),
    .count     (count)
  );

  // Address of each live request, popped as its word is accepted.
  fq_ring #(.DEPTH(DEPTH), .W(XLEN)) u_tags (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (resp_take),
    .head_data (tag_head),
    .count     (tag_count)
  );

  // ------------------------------------------------------------- next state
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    last_d     = last_q;

    // Remember what was last shown so an empty queue holds its outputs.
    if (out_vld) last_d = out_ent;

    case ({req_fire, bus.resp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: ;
    endcase

    if (bus.redirect) begin
      pc_d       = align_pc(bus.redirect_pc);
      drop_cnt_d = inflight_q - CW'(bus.resp_valid);
    end else begin
      if (req_fire)  pc_d       = pc_q + PC_STEP;
      if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end

    state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      last_q     <= last_d;
    end
  end

  // ------------------------------------------------------------- assertions
  // The credit rule keeps the entry queue from overflowing; a response into
  // a full queue or with nothing outstanding means the memory misbehaved.
  a_resp_outstanding: assert property (@(posedge clk) disable iff (reset)
    bus.resp_valid |-> inflight_q != '0);
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    resp_take |-> count != CW'(DEPTH));
  // Every non-discarded outstanding request owns exactly one tag.
  a_tag_track: assert property (@(posedge clk) disable iff (reset)
    tag_count == inflight_q - drop_cnt_q);

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory port and the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory. Returned instructions are buffered with their NPC and presented to IF/ID under a valid/ready handshake. Decode's stall (`disable_IR`) applies backpressure; a redirect (branch/jump/KILL) flushes buffered and in-flight instructions.

## Interface
- `DEPTH`, 4 — queue entries; power of two, ≥2; also the cap on buffered + in-flight requests.
- `RESET_PC`, 32'h0000_0000 — fetch PC after reset.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high; sampled on `clk` rising edge.
- `req_valid` out 1 — fetch request to instruction memory.
- `req_addr` out 32 — fetch address, word aligned.
- `req_ready` in 1 — memory accepts request this cycle.
- `resp_valid` in 1 — instruction returned (in request order).
- `resp_instr` in 32 — returned instruction word.
- `redirect` in 1 — flush and refetch (KILL / taken PCsrc).
- `redirect_pc` in 32 — new fetch PC (`PC_offset` / `PC_regRs` after selection).
- `out_valid` out 1 — `out_instr`/`out_npc` valid toward IF/ID.
- `out_ready` in 1 — IF/ID accepts (driven as `!disable_IR`).
- `out_instr` out 32 — instruction at queue head.
- `out_npc` out 32 — address of head instruction + 4.

## Operation
- Fetch PC register `pc`; request accepted when `req_valid && req_ready`, then `pc <= pc + 4` (mod 2^32, wraps silently).
- `req_valid = !reset && (count + inflight < DEPTH)`; `req_addr = pc`.
- `inflight` increments on accept, decrements on `resp_valid`; both in one cycle → unchanged.
- Each accepted request pushes its address into a small tag FIFO (depth `DEPTH`), so `out_npc` = tag + 4 is stored with the instruction.
- On `resp_valid` with `drop_cnt == 0`: write {instr, npc} at tail, `count++`.
- Pop when `out_valid && out_ready`; push and pop in one cycle → `count` unchanged.
- States: RUN (`drop_cnt == 0`), DRAIN (`drop_cnt > 0`).
- On `redirect`: `count <= 0`, head/tail reset, `pc <= redirect_pc`, `drop_cnt <= inflight` (minus 1 if `resp_valid` in the same cycle), tag FIFO cleared; enter DRAIN if result > 0.
- In DRAIN, each `resp_valid` is discarded and decrements `drop_cnt`; new requests may issue during DRAIN (in-order returns guarantee correct discard).
- Redirect-cycle priority: redirect wins over push, pop and request; `req_valid` forced 0 in the redirect cycle; a concurrent `out_ready` handshake is void.
- Misaligned `redirect_pc`: low two bits forced to 0.

## Timing
- Reset values: `req_valid` 0, `req_addr` `RESET_PC`, `out_valid` 0, `out_instr` 0, `out_npc` 0; `count`, `inflight`, `drop_cnt` 0; state RUN.
- Memory shares `reset`, so no responses arrive for pre-reset requests; reset mid-DRAIN returns to RUN.
- Latency without bypass: `resp_valid` in cycle N → `out_valid` in cycle N+1.
- Full (`count == DEPTH`): no push is possible because credit rule blocks requests; a `resp_valid` while full is a protocol error (assertion).
- Empty: `out_valid` 0, `out_instr`/`out_npc` hold the last value.
- First request after redirect: cycle after `redirect`, address `redirect_pc`.
- `out_valid` stays 1 and outputs stay stable while `out_ready` is 0.

## Configuration
- `FETCHQ_BYPASS_EN` defined: when `count == 0`, `drop_cnt == 0` and `resp_valid`, the response drives `out_*` combinationally in the same cycle. If `out_ready` is high it is consumed without a write; otherwise it is written normally. Latency becomes 0 cycles.
- Not defined: all responses go through storage; latency is 1 cycle; no combinational path from `resp_*` to `out_*`.

## Structure
- Shared package `cpu_pkg`: `XLEN` (32), `INSTR_W`, `RESET_PC` default, `PC_STEP` (4), and a typedef for the `{instr, npc}` queue entry.
- One sub-module, `fq_ring`: a parameterised ring buffer (push, pop, clear, count, head data) used for both the entry queue and the address-tag FIFO.

## Test plan
- Reset, `req_ready`=1, 1-cycle memory, `out_ready`=1 → requests 0x0, 0x4, 0x8…; `out_npc` sequence 0x4, 0x8, 0xC; one instruction per cycle after fill.
- Hold `out_ready`=0 for 10 cycles → exactly `DEPTH`=4 requests accepted, `req_valid` drops, `out_*` stable; release → 4 pops in consecutive cycles, fetching resumes.
- 3-cycle memory, redirect to 0x100 with 2 in flight → the 2 responses are discarded, first `out_instr` is from 0x100 with `out_npc` 0x104.
- `redirect` in the same cycle as `resp_valid` and `out_ready` handshake → nothing popped, the response is dropped, and `drop_cnt` = inflight−1.
- `pc` = 0xFFFF_FFFC → next request at 0x0000_0000, and that entry has `out_npc` 0x0.
- With `FETCHQ_BYPASS_EN`, empty queue, `resp_valid` with `out_ready`=1 → `out_valid` is 1 in the same cycle and `count` stays 0; without the macro → `out_valid` is 1 one cycle later.
